// File: rtl/spi_i2s_ctrl.sv
// ---------------------------------------------------------------------------
// spi_i2s_ctrl
// Run-control sequencer for the I2S shifter. It converts the software enable
// bit into a clean shifter enable. In transmit mode it waits for the TX FIFO
// to be preloaded first. On disable it lets the current stereo frame finish
// and then waits for the shifter to drain. It also keeps sticky
// underrun/overrun flags and a completed-frame counter.
//
// Optional feature macro: SPI_I2S_CTRL_IRQ_EN
//   When defined, irq is a registered OR of the enabled flags.
//   When undefined, irq is 0 and ie is ignored.
//
// Ports
//   i2s_clk_ctrl   in  : clock (rising edge)
//   rst_ctrl       in  : asynchronous active-high reset
//   i2se_req       in  : software enable bit
//   tx_mode        in  : 1 = transmit, 0 = receive (sampled in IDLE)
//   chside         in  : channel side from the shifter
//   tx_fifo_fill   in  : TX FIFO occupancy [3:0]
//   tx_fifo_acq    in  : shifter TX FIFO pop strobe
//   tx_shift_empty in  : shifter has no bits left
//   rx_fifo_wr     in  : shifter RX FIFO write strobe
//   rx_fifo_full   in  : RX FIFO full
//   err_clr        in  : clears udr and ovr
//   ie             in  : interrupt enables [1:0] (bit0 udr, bit1 ovr)
//   i2se           out : shifter enable
//   rx_enable      out : shifter receive enable
//   busy           out : controller not idle
//   udr            out : sticky TX underrun flag
//   ovr            out : sticky RX overrun flag
//   frame_cnt      out : completed frame count [CNT_W-1:0]
//   irq            out : interrupt request
// ---------------------------------------------------------------------------
module spi_i2s_ctrl #(
    parameter int PRELOAD  = 2,
    parameter int CNT_W    = 16,
    parameter int DRAIN_TO = 64
) (
    input  logic             i2s_clk_ctrl,
    input  logic             rst_ctrl,
    input  logic             i2se_req,
    input  logic             tx_mode,
    input  logic             chside,
    input  logic [3:0]       tx_fifo_fill,
    input  logic             tx_fifo_acq,
    input  logic             tx_shift_empty,
    input  logic             rx_fifo_wr,
    input  logic             rx_fifo_full,
    input  logic             err_clr,
    input  logic [1:0]       ie,
    output logic             i2se,
    output logic             rx_enable,
    output logic             busy,
    output logic             udr,
    output logic             ovr,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             irq
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       tmr_q, tmr_d;
    logic             chside_d_q, chside_d_d;
    logic             txm_q, txm_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             udr_q, udr_d;
    logic             ovr_q, ovr_d;

    logic chside_fall;
    logic tmr_done;
    logic leave_idle;

    assign chside_fall = chside_d_q & ~chside;
    assign tmr_done    = (tmr_q == 8'(DRAIN_TO - 1));
    assign leave_idle  = (state_q == IDLE) && (state_d != IDLE);

    // Outputs are pure decodes of registered state.
    assign i2se      = (state_q == RUN) || (state_q == DRAIN);
    assign rx_enable = i2se & ~txm_q;
    assign busy      = (state_q != IDLE);
    assign udr       = udr_q;
    assign ovr       = ovr_q;
    assign frame_cnt = frame_cnt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i2se_req) state_d = tx_mode ? ARM : RUN;
            end
            ARM: begin
                // Disable wins over a satisfied preload.
                if (!i2se_req)                        state_d = IDLE;
                else if (tx_fifo_fill >= 4'(PRELOAD)) state_d = RUN;
            end
            RUN: begin
                if (!i2se_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (chside_fall || tmr_done) state_d = STOP;
            end
            STOP: begin
                if ((tx_shift_empty && (!txm_q || tx_fifo_fill == 4'd0)) || tmr_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tmr_d       = (tmr_q == 8'hFF) ? tmr_q : tmr_q + 8'd1;
        txm_d       = txm_q;
        frame_cnt_d = frame_cnt_q;

        if (state_d != state_q) tmr_d = 8'd0;

        // Held at 0 in IDLE so the first active cycle can never see a fall.
        chside_d_d = (state_q == IDLE) ? 1'b0 : chside;

        if (leave_idle) begin
            txm_d       = tx_mode;
            frame_cnt_d = '0;
        end else if (((state_q == RUN) || (state_q == DRAIN)) && chside_fall) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        // A set condition in the same cycle as err_clr keeps the flag.
        udr_d = ((state_q == RUN) && txm_q && tx_fifo_acq && (tx_fifo_fill == 4'd0))
                | (udr_q & ~err_clr);
        ovr_d = (rx_enable && rx_fifo_wr && rx_fifo_full) | (ovr_q & ~err_clr);
    end

    always_ff @(posedge i2s_clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            state_q     <= IDLE;
            tmr_q       <= 8'd0;
            chside_d_q  <= 1'b0;
            txm_q       <= 1'b0;
            frame_cnt_q <= '0;
            udr_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            chside_d_q  <= chside_d_d;
            txm_q       <= txm_d;
            frame_cnt_q <= frame_cnt_d;
            udr_q       <= udr_d;
            ovr_q       <= ovr_d;
        end
    end

`ifdef SPI_I2S_CTRL_IRQ_EN
    logic irq_q;

    always_ff @(posedge i2s_clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) irq_q <= 1'b0;
        else          irq_q <= (udr_q & ie[0]) | (ovr_q & ie[1]);
    end

    assign irq = irq_q;
`else
    logic unused_ie;
    assign unused_ie = ^ie;
    assign irq       = 1'b0;
`endif

endmodule
